// File: rtl/meteor_pkg.sv
// rtl/meteor_pkg.sv - shared state type, default geometry and LFSR constants for meteor_sprite
package meteor_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, FALL} meteor_state_t;

  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_ACTIVE_ROWS = 480;
  localparam int DEF_TOTAL_COLS  = 800;
  localparam int DEF_TOTAL_ROWS  = 525;
  localparam int DEF_METEOR_SIZE = 16;
  localparam int DEF_FALL_SPEED  = 2;
  localparam int DEF_SPAWN_DELAY = 30;

  // x^10 + x^7 + 1: feedback from bits 9 and 6
  localparam logic [9:0] LFSR_SEED = 10'h001;
  localparam logic [9:0] LFSR_TAPS = 10'h240;

endpackage

// File: rtl/meteor_sprite_lfsr10.sv
// rtl/meteor_sprite_lfsr10.sv - 10-bit Fibonacci LFSR spawn source (used with METEOR_LFSR_EN)
module lfsr10
  import meteor_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       enable,
  output logic [9:0] value
);

  logic [9:0] lfsr_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (enable) begin
      lfsr_q <= {lfsr_q[8:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/meteor_sprite.sv
// rtl/meteor_sprite.sv - meteor spawn/fall FSM and pixel draw; METEOR_LFSR_EN selects LFSR spawn columns
module meteor_sprite
  import meteor_pkg::*;
#(
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
  parameter int METEOR_SIZE = DEF_METEOR_SIZE,
  parameter int FALL_SPEED  = DEF_FALL_SPEED,
  parameter int SPAWN_DELAY = DEF_SPAWN_DELAY
)
(
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_HSync,
  input  logic       i_VSync,
  input  logic [9:0] i_Col_Count,
  input  logic [9:0] i_Row_Count,
  input  logic       i_Game_Active,
  input  logic       i_Hit,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Draw,
  output logic [9:0] o_Meteor_X,
  output logic [9:0] o_Meteor_Y,
  output logic       o_Landed
);

  localparam logic [10:0] COLS11   = 11'(ACTIVE_COLS);
  localparam logic [10:0] ROWS11   = 11'(ACTIVE_ROWS);
  localparam logic [10:0] TCOLS11  = 11'(TOTAL_COLS);
  localparam logic [10:0] TROWS11  = 11'(TOTAL_ROWS);
  localparam logic [10:0] SIZE11   = 11'(METEOR_SIZE);
  localparam logic [10:0] SPEED11  = 11'(FALL_SPEED);
  localparam logic [10:0] XMAX11   = 11'(ACTIVE_COLS - METEOR_SIZE);
  localparam logic [10:0] LAND11   = 11'(ACTIVE_ROWS - METEOR_SIZE);
  localparam logic [5:0]  DELAY6   = 6'(SPAWN_DELAY);

  meteor_state_t state, state_next;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        landed_d, draw_d, spawn, tick;
  logic [9:0]  v, spawn_x;
  logic [10:0] col11, row11, x11, y11, y_fall;

  assign col11  = {1'b0, i_Col_Count};
  assign row11  = {1'b0, i_Row_Count};
  assign x11    = {1'b0, x_q};
  assign y11    = {1'b0, y_q};
  assign y_fall = y11 + SPEED11;

  // First pixel of the first blanking line; the count stage never exceeds the totals
  assign tick = (i_Col_Count == 10'd0) && (row11 == ROWS11) && (row11 < TROWS11) && (col11 < TCOLS11);

`ifdef METEOR_LFSR_EN
  lfsr10 u_lfsr (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .enable (1'b1),
    .value  (v)
  );
`else
  logic [9:0] det_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      det_q <= '0;
    end else if (spawn) begin
      det_q <= det_q + 10'd97;
    end
  end

  assign v = det_q;
`endif

  // Fold values past the last legal column back into range
  assign spawn_x = ({1'b0, v} <= XMAX11) ? v : v - 10'd512;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!i_Game_Active) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = WAIT;
        WAIT:    if (tick && cnt_q == 6'd0) state_next = FALL;
        FALL:    if (i_Hit || (tick && y_fall >= LAND11)) state_next = WAIT;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    landed_d = 1'b0;
    spawn    = 1'b0;
    if (!i_Game_Active) begin
      y_d   = '0;
      cnt_d = '0;
    end else begin
      case (state)
        IDLE: cnt_d = DELAY6;
        WAIT: begin
          if (tick) begin
            if (cnt_q == 6'd0) begin
              spawn = 1'b1;
              x_d   = spawn_x;
              y_d   = '0;
            end else begin
              cnt_d = cnt_q - 6'd1;
            end
          end
        end
        FALL: begin
          // A hit outranks a landing on the same cycle
          if (i_Hit) begin
            cnt_d = DELAY6;
          end else if (tick) begin
            if (y_fall >= LAND11) begin
              landed_d = 1'b1;
              cnt_d    = DELAY6;
            end else begin
              y_d = y_fall[9:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign draw_d = (state == FALL) &&
                  (col11 >= x11) && (col11 < x11 + SIZE11) &&
                  (row11 >= y11) && (row11 < y11 + SIZE11) &&
                  (col11 < COLS11) && (row11 < ROWS11);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      o_Landed <= 1'b0;
      o_Draw   <= 1'b0;
      o_HSync  <= 1'b0;
      o_VSync  <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      o_Landed <= landed_d;
      o_Draw   <= draw_d;
      o_HSync  <= i_HSync;
      o_VSync  <= i_VSync;
    end
  end

  assign o_Meteor_X = x_q;
  assign o_Meteor_Y = y_q;

endmodule

// File: tb/tb_meteor_sprite.sv
// tb/tb_meteor_sprite.sv - randomized scoreboard bench for meteor_sprite against a frame-level model
module tb_meteor_sprite;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_HSync = 1'b0, i_VSync = 1'b0;
  logic [9:0] i_Col_Count = '0, i_Row_Count = '0;
  logic       i_Game_Active = 1'b0, i_Hit = 1'b0;
  logic       o_HSync, o_VSync, o_Draw, o_Landed;
  logic [9:0] o_Meteor_X, o_Meteor_Y;

  meteor_sprite dut (
    .i_Clk         (i_Clk),
    .i_Rst         (i_Rst),
    .i_HSync       (i_HSync),
    .i_VSync       (i_VSync),
    .i_Col_Count   (i_Col_Count),
    .i_Row_Count   (i_Row_Count),
    .i_Game_Active (i_Game_Active),
    .i_Hit         (i_Hit),
    .o_HSync       (o_HSync),
    .o_VSync       (o_VSync),
    .o_Draw        (o_Draw),
    .o_Meteor_X    (o_Meteor_X),
    .o_Meteor_Y    (o_Meteor_Y),
    .o_Landed      (o_Landed)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       draw;
    logic [9:0] x;
    logic [9:0] y;
    logic       landed;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model: 0 idle, 1 waiting out the spawn delay, 2 falling
  int m_mode, m_frames, m_x, m_y, m_spawns, m_lands, m_hits_on_land;

  function automatic int spawn_col(int n);
    int v;
    v = (n * 97) % 1024;
    return (v <= 640 - 16) ? v : v - 512;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge i_Clk) begin
    #1;
    if (mon_en && sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      check("hsync",  32'(o_HSync),    32'(mon_e.hs));
      check("vsync",  32'(o_VSync),    32'(mon_e.vs));
      check("draw",   32'(o_Draw),     32'(mon_e.draw));
      check("x",      32'(o_Meteor_X), 32'(mon_e.x));
      check("y",      32'(o_Meteor_Y), 32'(mon_e.y));
      check("landed", 32'(o_Landed),   32'(mon_e.landed));
    end
  end

  task automatic drive(input bit ga, input bit hit, input int col, input int row);
    exp_t e;
    bit   tick;
    @(negedge i_Clk);
    i_Game_Active = ga;
    i_Hit         = hit;
    i_Col_Count   = 10'(col);
    i_Row_Count   = 10'(row);
    i_HSync       = 1'($urandom);
    i_VSync       = 1'($urandom);
    tick = (col == 0) && (row == 480);
    e.hs   = i_HSync;
    e.vs   = i_VSync;
    e.draw = (m_mode == 2) && col >= m_x && col < m_x + 16 && row >= m_y && row < m_y + 16
             && col < 640 && row < 480;
    e.landed = 1'b0;
    if (!ga) begin
      m_mode = 0; m_y = 0; m_frames = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_frames = 30;
    end else if (m_mode == 1) begin
      if (tick) begin
        if (m_frames == 0) begin
          m_mode = 2; m_x = spawn_col(m_spawns); m_y = 0; m_spawns++;
        end else begin
          m_frames--;
        end
      end
    end else begin
      if (hit) begin
        if (tick && m_y + 2 >= 464) m_hits_on_land++;
        m_mode = 1; m_frames = 30;
      end else if (tick) begin
        if (m_y + 2 >= 464) begin
          e.landed = 1'b1; m_lands++; m_mode = 1; m_frames = 30;
        end else begin
          m_y += 2;
        end
      end
    end
    e.x = 10'(m_x);
    e.y = 10'(m_y);
    sbq.push_back(e);
  endtask

  task automatic pixel(input bit ga);
    int c, r;
    bit hit;
    if ($urandom_range(0, 1) == 0) begin
      c = m_x + $urandom_range(0, 19) - 2;
      r = m_y + $urandom_range(0, 19) - 2;
      if (c < 0) c = 0;
      if (r < 0) r = 0;
    end else begin
      c = $urandom_range(0, 799);
      r = $urandom_range(0, 524);
    end
    hit = (m_mode == 2) && ($urandom_range(0, 1499) == 0);
    drive(ga, hit, c, r);
  endtask

  task automatic tick_cycle(input bit allow_hit);
    bit hit;
    hit = allow_hit && (m_mode == 2) && (m_y + 2 >= 464) && ($urandom_range(0, 1) == 0);
    drive(1'b1, hit, 0, 480);
  endtask

  initial begin
    int drop_n;
    int waited;
    m_mode = 0; m_frames = 0; m_x = 0; m_y = 0; m_spawns = 0; m_lands = 0; m_hits_on_land = 0;
    drop_n = 0;

    repeat (3) @(negedge i_Clk);
    check("rst_x",      32'(o_Meteor_X), 32'd0);
    check("rst_y",      32'(o_Meteor_Y), 32'd0);
    check("rst_draw",   32'(o_Draw),     32'd0);
    check("rst_landed", 32'(o_Landed),   32'd0);
    check("rst_hsync",  32'(o_HSync),    32'd0);
    check("rst_vsync",  32'(o_VSync),    32'd0);
    i_Rst  = 1'b0;
    mon_en = 1'b1;

    for (int t = 0; t < 2500; t++) begin
      tick_cycle(1'b1);
      for (int k = 0; k < int'($urandom_range(2, 5)); k++) begin
        if (drop_n == 0 && $urandom_range(0, 3999) == 0) drop_n = $urandom_range(1, 4);
        if (drop_n > 0) drop_n--;
        pixel(drop_n == 0);
      end
    end

    // Drop the game mid-fall while scanning inside the sprite
    waited = 0;
    while (m_mode != 2 && waited < 400) begin
      tick_cycle(1'b0);
      pixel(1'b1);
      waited++;
    end
    check("reach_fall_1", 32'(m_mode == 2), 32'd1);
    tick_cycle(1'b0);
    drive(1'b0, 1'b0, m_x + 1, m_y + 1);
    drive(1'b0, 1'b0, m_x + 1, m_y + 1);
    drive(1'b1, 1'b0, m_x + 1, 1);

    waited = 0;
    while (m_mode != 2 && waited < 400) begin
      tick_cycle(1'b0);
      pixel(1'b1);
      waited++;
    end
    check("reach_fall_2", 32'(m_mode == 2), 32'd1);
    repeat (5) tick_cycle(1'b0);
    drive(1'b1, 1'b0, m_x + 2, m_y + 2);
    drive(1'b1, 1'b0, m_x + 2, m_y + 2);

    // Asynchronous reset between clock edges
    @(posedge i_Clk);
    #2;
    mon_en = 1'b0;
    check("pre_rst_draw", 32'(o_Draw), 32'd1);
    i_Rst = 1'b1;
    #1;
    check("async_x",      32'(o_Meteor_X), 32'd0);
    check("async_y",      32'(o_Meteor_Y), 32'd0);
    check("async_draw",   32'(o_Draw),     32'd0);
    check("async_landed", 32'(o_Landed),   32'd0);
    check("async_hsync",  32'(o_HSync),    32'd0);
    check("async_vsync",  32'(o_VSync),    32'd0);

    check("saw_landing", 32'(m_lands > 0),   32'd1);
    check("saw_spawns",  32'(m_spawns >= 7), 32'd1);
    check("sb_drained",  32'(sbq.size()),    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
